ioregs_6502: RTL

Parametrised memory-mapped I/O register page for the 6502 core, successor to the fixed `0xDF00` control page. It decodes one 256-byte page and provides:
- the CPU/SPI control CSR with a registered icache-invalidate pulse;
- a GPIO bank of configurable width with input synchronisers, rising/falling edge capture, write-1-to-clear pending flags and a level interrupt;
- an optional 16-bit prescaled reload timer.

Reads are combinational; all state is synchronous to the CPU clock.

---
 rtl/ioregs_6502.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ioregs_6502.sv
// ioregs_6502: one 256-byte I/O page for the 6502 core.
// It holds the CPU/SPI control CSR, which also issues the icache-invalidate pulse.
// It holds a GPIO bank with synchronisers, edge capture, W1C pending flags and a level irq.
// Define IOREGS_TIMER_EN to add the 16-bit prescaled reload timer at addresses 8..C.

// One GPIO channel: 2-flop synchroniser, previous-value flop, edge qualify.
module ioregs_6502_gpio_lane (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic rise_en,
  input  logic fall_en,
  output logic s,
  output logic hit
);
  logic s1, s2, p;

  // synchronise the pin, then keep the previous synchronised value
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign s   = s2;
  assign hit = (s2 & ~p & rise_en) | (~s2 & p & fall_en);
endmodule

module ioregs_6502 #(
  parameter logic [7:0] PAGE     = 8'hDF,
  parameter int         GPIO_W   = 4,
  parameter int         PRESCALE = 16,
  parameter logic [7:0] CSR_RST  = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_en,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_rdy,
  output logic              int_en,
  output logic [7:0]        int_rdata,
  output logic              icache_en,
  output logic              skip_int,
  output logic              spi_phase,
  output logic              spi_delay,
  output logic              spi_fast,
  output logic              icache_inv,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);
  logic [3:0]        ra;
  logic              acc, wr_acc;
  logic [4:0]        csr;
  logic [GPIO_W-1:0] rise_en, fall_en, pend, mask;
  logic [GPIO_W-1:0] gpio_s, gpio_hit, pend_clr;
  logic              tmr_irq;
  logic              unused_bits;

  assign ra          = cpu_addr[3:0];
  assign int_en      = (cpu_addr[15:8] == PAGE);
  assign acc         = cpu_en && cpu_rdy && int_en;
  assign wr_acc      = acc && cpu_wr;
  // only the low nibble selects a register; the rest of the page aliases
  assign unused_bits = ^{cpu_addr[7:4], cpu_wdata};

  assign {spi_fast, spi_delay, spi_phase, skip_int, icache_en} = csr;

  // CSR storage and the registered invalidate pulse (bit 7 is never stored)
  always_ff @(posedge clk) begin
    if (rst) begin
      csr        <= CSR_RST[4:0];
      icache_inv <= 1'b0;
    end else begin
      icache_inv <= wr_acc && (ra == 4'h0) && cpu_wdata[7];
      if (wr_acc && ra == 4'h0) csr <= cpu_wdata[4:0];
    end
  end

  genvar g;
  generate
    for (g = 0; g < GPIO_W; g++) begin : g_lane
      ioregs_6502_gpio_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .pin     (gpio_in[g]),
        .rise_en (rise_en[g]),
        .fall_en (fall_en[g]),
        .s       (gpio_s[g]),
        .hit     (gpio_hit[g])
      );
    end
  endgenerate

  assign pend_clr = (wr_acc && ra == 4'h6) ? cpu_wdata[GPIO_W-1:0] : '0;

  // GPIO control registers; pending set wins over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      pend     <= '0;
      mask     <= '0;
    end else begin
      if (wr_acc && ra == 4'h2) gpio_out <= cpu_wdata[GPIO_W-1:0];
      if (wr_acc && ra == 4'h3) gpio_oe  <= cpu_wdata[GPIO_W-1:0];
      if (wr_acc && ra == 4'h4) rise_en  <= cpu_wdata[GPIO_W-1:0];
      if (wr_acc && ra == 4'h5) fall_en  <= cpu_wdata[GPIO_W-1:0];
      if (wr_acc && ra == 4'h7) mask     <= cpu_wdata[GPIO_W-1:0];
      pend <= (pend & ~pend_clr) | gpio_hit;
    end
  end

`ifdef IOREGS_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [15:0] rld, cnt;
  logic [7:0]  snap;
  logic [PW-1:0] presc;
  logic        run, periodic, tirq_en, expired;
  logic        ctrl_wr, tick, expire;

  assign ctrl_wr = wr_acc && (ra == 4'hC);
  // a CTRL write in the same cycle overrides the tick
  assign tick    = run && !ctrl_wr && (presc == PW'(PRESCALE - 1));
  assign expire  = tick && (cnt == 16'd0);
  assign tmr_irq = expired && tirq_en;

  // timer: reload on run write, prescaled decrement, expiry and snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      rld      <= '0;
      cnt      <= '0;
      snap     <= '0;
      presc    <= '0;
      run      <= 1'b0;
      periodic <= 1'b0;
      tirq_en  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      if (wr_acc && ra == 4'h8) rld[7:0]  <= cpu_wdata;
      if (wr_acc && ra == 4'h9) rld[15:8] <= cpu_wdata;
      if (acc && !cpu_wr && ra == 4'hA) snap <= cnt[15:8];
      expired <= (expired & ~(ctrl_wr & cpu_wdata[7])) | expire;
      if (ctrl_wr) begin
        run      <= cpu_wdata[0];
        periodic <= cpu_wdata[1];
        tirq_en  <= cpu_wdata[2];
        if (cpu_wdata[0]) begin
          cnt   <= rld;
          presc <= '0;
        end
      end else if (run) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else if (periodic) cnt <= rld;
          else run <= 1'b0;
        end
      end
    end
  end
`else
  assign tmr_irq = 1'b0;
`endif

  assign irq = (|(pend & mask)) | tmr_irq;

  // combinational read mux; unlisted addresses and bits read 0
  always_comb begin
    int_rdata = 8'h00;
    case (ra)
      4'h0: int_rdata = {3'b000, csr};
      4'h1: int_rdata = 8'(gpio_s);
      4'h2: int_rdata = 8'(gpio_out);
      4'h3: int_rdata = 8'(gpio_oe);
      4'h4: int_rdata = 8'(rise_en);
      4'h5: int_rdata = 8'(fall_en);
      4'h6: int_rdata = 8'(pend);
      4'h7: int_rdata = 8'(mask);
`ifdef IOREGS_TIMER_EN
      4'h8: int_rdata = rld[7:0];
      4'h9: int_rdata = rld[15:8];
      4'hA: int_rdata = cnt[7:0];
      4'hB: int_rdata = snap;
      4'hC: int_rdata = {expired, 4'b0000, tirq_en, periodic, run};
`endif
      default: int_rdata = 8'h00;
    endcase
  end
endmodule
